// File: rtl/token_ring_arbiter.sv
// Token-ring arbiter: grants one of N 4-phase requesters, searching from the
// token; a grant is revoked after MAX_HOLD cycles and the owner must drain.
// Ports: clk, reset (async, high), req[N], ack[N] one-hot grant, token[3]
// search start, busy (not idle), timeout pulse, grant_cnt[8] grants mod 256.
module token_ring_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] ack,
  output logic [2:0]   token,
  output logic         busy,
  output logic         timeout,
  output logic [7:0]   grant_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DRAIN
  } state_t;

  state_t     state;
  logic [2:0] owner;
  logic [7:0] hold;

  // Widen req so a 3-bit ring index is always a legal select.
  logic [7:0] req8;
  logic       own_req;
  logic [2:0] nxt_tok;

  assign req8    = 8'(req);
  assign own_req = req8[owner];
  assign nxt_tok = (owner == 3'(N - 1)) ? 3'd0 : owner + 3'd1;

  // Ring search: walk offsets from the far end down so the
  // entry closest to the token overrides later candidates.
  logic       found;
  logic [2:0] pick;
  logic [3:0] idx;
  logic [7:0] pick_oh;

  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    idx   = 4'd0;
    for (int j = N - 1; j >= 0; j--) begin
      idx = {1'b0, token} + 4'(j);
      if (idx >= 4'(N)) idx = idx - 4'(N);
      if (req8[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  assign pick_oh = 8'd1 << pick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ack       <= '0;
      token     <= 3'd0;
      owner     <= 3'd0;
      hold      <= 8'd0;
      timeout   <= 1'b0;
      grant_cnt <= 8'd0;
      busy      <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            ack       <= pick_oh[N-1:0];
            owner     <= pick;
            hold      <= 8'd0;
            grant_cnt <= grant_cnt + 8'd1;
            state     <= GRANT;
            busy      <= 1'b1;
          end else begin
            ack  <= '0;
            busy <= 1'b0;
          end
        end
        GRANT: begin
          // Release wins over a coincident timeout.
          if (!own_req) begin
            ack   <= '0;
            token <= nxt_tok;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (hold == 8'(MAX_HOLD - 1)) begin
            ack     <= '0;
            timeout <= 1'b1;
            state   <= DRAIN;
          end else if (hold != 8'(MAX_HOLD)) begin
            hold <= hold + 8'd1;
          end
        end
        DRAIN: begin
          if (!own_req) begin
            token <= nxt_tok;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
